prio_code_decoder: RTL

//  Inverse of the 16-bit priority encoder: consumes a stream of 8-bit bit-index codes,

---
 rtl/prio_code_decoder_pkg.sv | 11 +
 rtl/prio_code_decoder_idx_onehot.sv | 17 +
 rtl/prio_code_decoder.sv | 132 +++++++++++++
 3 files changed

// File: rtl/prio_code_decoder_pkg.sv
// Constants shared by the priority encoder and decoder: code space, terminator
// and decoder FSM state encoding.
package prio_code_decoder_pkg;
   localparam int         WIDTH     = 16;
   localparam int         IDX_W     = $clog2(WIDTH);
   localparam logic [7:0] NONE_CODE = 8'hF0;

   localparam logic [1:0] ACCUM   = 2'd0;
   localparam logic [1:0] EMIT_HI = 2'd1;
   localparam logic [1:0] EMIT_LO = 2'd2;
endpackage

// File: rtl/prio_code_decoder_idx_onehot.sv
// Turns an 8-bit index code into a WIDTH-bit one-hot vector; codes outside
// 0..WIDTH-1 produce an all-zero vector and in_range=0.
module idx_onehot
   import prio_code_decoder_pkg::*;
(
   input  logic [7:0]       code,
   output logic [WIDTH-1:0] onehot,
   output logic             in_range
);

   logic [WIDTH-1:0] one;

   assign one      = {{(WIDTH-1){1'b0}}, 1'b1};
   assign in_range = (code < 8'(WIDTH));
   assign onehot   = in_range ? (one << code[IDX_W-1:0]) : '0;

endmodule

// File: rtl/prio_code_decoder.sv
// Rebuilds a WIDTH-bit vector from a frame of bit-index codes closed by NONE_CODE
// and streams it out as two bytes, high byte first.
module prio_code_decoder
   import prio_code_decoder_pkg::*;
#(
   parameter int MAX_CODES = 16
)
(
   input  logic       clk,
   input  logic       rst,
   input  logic [7:0] code_in,
   input  logic       code_valid,
   output logic       code_ready,
   output logic [7:0] out_byte,
   output logic       out_valid,
   output logic       out_last,
   input  logic       out_ready,
   input  logic       clr_flags,
   output logic       err_code,
   output logic       ovf,
   output logic [7:0] frame_cnt,
   output logic [1:0] dbg_state
);

   // Handshakes: a word moves on a rising edge where valid and ready are both high.
   // The producer holds data stable while valid & !ready; ready never depends on valid.
   localparam int CNT_W = $clog2(MAX_CODES + 1);

   logic [1:0]       state;
   logic [WIDTH-1:0] acc;
   logic [WIDTH-1:0] out_reg;
   logic [CNT_W-1:0] cnt;
   logic [WIDTH-1:0] onehot;
   logic             in_range;
   logic             code_xfer;
   logic             out_xfer;
   logic             is_none;
   logic             hit_max;
   logic             set_err;
   logic             set_ovf;

   idx_onehot u_idx_onehot (
      .code     (code_in),
      .onehot   (onehot),
      .in_range (in_range)
   );

   assign code_ready = (state == ACCUM);
   assign code_xfer  = code_valid & code_ready;
   assign out_xfer   = out_valid & out_ready;
   assign is_none    = (code_in == NONE_CODE);
   assign hit_max    = (cnt == CNT_W'(MAX_CODES - 1));
   assign set_err    = code_xfer & !in_range & !is_none;
   assign set_ovf    = code_xfer & in_range & hit_max;
   assign dbg_state  = state;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state     <= ACCUM;
         acc       <= '0;
         cnt       <= '0;
         out_reg   <= '0;
         frame_cnt <= 8'd0;
      end else begin
         case (state)
            ACCUM: begin
               if (code_xfer) begin
                  if (in_range) begin
                     if (hit_max) begin
                        out_reg <= acc | onehot;
                        acc     <= '0;
                        cnt     <= '0;
                        state   <= EMIT_HI;
                     end else begin
                        acc <= acc | onehot;
                        cnt <= cnt + 1'b1;
                     end
                  end else if (is_none) begin
                     out_reg <= acc;
                     acc     <= '0;
                     cnt     <= '0;
                     state   <= EMIT_HI;
                  end
               end
            end
            EMIT_HI: if (out_ready) state <= EMIT_LO;
            EMIT_LO: begin
               if (out_ready) begin
                  state     <= ACCUM;
                  frame_cnt <= frame_cnt + 8'd1;
               end
            end
            default: state <= ACCUM;
         endcase
      end
   end

   // A flag being set in the same cycle as clr_flags stays set.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         err_code <= 1'b0;
         ovf      <= 1'b0;
      end else begin
         if (set_err)        err_code <= 1'b1;
         else if (clr_flags) err_code <= 1'b0;
         if (set_ovf)        ovf <= 1'b1;
         else if (clr_flags) ovf <= 1'b0;
      end
   end

   always_comb begin
      out_byte  = 8'h00;
      out_valid = 1'b0;
      out_last  = 1'b0;
      case (state)
         EMIT_HI: begin
            out_byte  = out_reg[WIDTH-1:WIDTH-8];
            out_valid = 1'b1;
         end
         EMIT_LO: begin
            out_byte  = out_reg[7:0];
            out_valid = 1'b1;
            out_last  = 1'b1;
         end
         default: ;
      endcase
   end

   logic unused_xfer;
   assign unused_xfer = out_xfer;

endmodule
